// File: rtl/bpred_update_ctrl.sv
// Branch-predictor port arbiter: shares one predictor port between fetch lookups and
// in-order training updates, tracks in-flight predictions, and flushes on mispredict.
// Optional statistics counters are built only when BPRED_STATS_EN is defined.
module bpred_update_ctrl #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lk_req,
    input  logic [PC_W-1:0]            lk_pc,
    output logic                       lk_gnt,
    output logic                       pred_valid,
    output logic                       pred_taken,
    input  logic                       rs_valid,
    input  logic                       rs_taken,
    output logic                       tp_en,
    output logic                       tp_we,
    output logic                       tp_br,
    output logic [PC_W-1:0]            tp_pc,
    input  logic                       tp_hit,
    output logic                       flush,
    output logic [$clog2(DEPTH):0]     occ,
    output logic                       err_underflow,
    output logic [15:0]                st_lookups,
    output logic [15:0]                st_mispred
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [OW-1:0]   occ_q;
    logic            pred_valid_q;
    logic            pred_taken_q;
    logic            flush_q;
    logic            err_q;

    logic [PC_W-1:0] pc_mem   [DEPTH];
    logic            pred_mem [DEPTH];

    logic            do_update;
    logic            do_lookup;
    logic            mispredict;
    logic            underflow;

    // Updates win the port; an rs_valid that cannot pop (empty or flushing) is an underflow.
    always_comb begin
        do_update  = !rst && rs_valid && (state_q == ST_RUN) && (occ_q != '0);
        do_lookup  = !rst && !do_update && lk_req && (state_q == ST_RUN)
                     && (occ_q < OW'(DEPTH));
        underflow  = !rst && rs_valid && !do_update;
        mispredict = do_update && (rs_taken != pred_mem[rd_ptr_q]);
    end

    always_comb begin
        tp_en  = do_update || do_lookup;
        tp_we  = do_update;
        tp_br  = do_update && rs_taken;
        tp_pc  = '0;
        if (do_update) begin
            tp_pc = pc_mem[rd_ptr_q];
        end else if (do_lookup) begin
            tp_pc = lk_pc;
        end
    end

    // Storage is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_lookup) begin
            pc_mem[wr_ptr_q]   <= lk_pc;
            pred_mem[wr_ptr_q] <= tp_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            flush_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            pred_valid_q <= do_lookup;
            if (do_lookup) begin
                pred_taken_q <= tp_hit;
            end
            flush_q <= mispredict;
            if (underflow) begin
                err_q <= 1'b1;
            end
            if (mispredict) begin
                state_q  <= ST_FLUSH;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
            end else begin
                if (state_q == ST_FLUSH) begin
                    state_q <= ST_RUN;
                end
                if (do_update) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                    occ_q    <= occ_q - OW'(1);
                end else if (do_lookup) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                    occ_q    <= occ_q + OW'(1);
                end
            end
        end
    end

    assign lk_gnt        = do_lookup;
    assign pred_valid    = pred_valid_q;
    assign pred_taken    = pred_taken_q;
    assign flush         = flush_q;
    assign occ           = occ_q;
    assign err_underflow = err_q;

`ifdef BPRED_STATS_EN
    logic [15:0] st_lookups_q;
    logic [15:0] st_mispred_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_lookups_q <= '0;
            st_mispred_q <= '0;
        end else begin
            if (do_lookup && (st_lookups_q != 16'hFFFF)) begin
                st_lookups_q <= st_lookups_q + 16'd1;
            end
            if (mispredict && (st_mispred_q != 16'hFFFF)) begin
                st_mispred_q <= st_mispred_q + 16'd1;
            end
        end
    end

    assign st_lookups = st_lookups_q;
    assign st_mispred = st_mispred_q;
`else
    assign st_lookups = 16'd0;
    assign st_mispred = 16'd0;
`endif

endmodule

// File: tb/tb_bpred_update_ctrl.sv
// Directed testbench for bpred_update_ctrl: lookup/update arbitration, mispredict flush,
// full stall, underflow, reset and statistics.
module tb_bpred_update_ctrl;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             lk_req;
    logic [PC_W-1:0]  lk_pc;
    logic             lk_gnt;
    logic             pred_valid;
    logic             pred_taken;
    logic             rs_valid;
    logic             rs_taken;
    logic             tp_en;
    logic             tp_we;
    logic             tp_br;
    logic [PC_W-1:0]  tp_pc;
    logic             tp_hit;
    logic             flush;
    logic [2:0]       occ;
    logic             err_underflow;
    logic [15:0]      st_lookups;
    logic [15:0]      st_mispred;

    int checks = 0;
    int fails  = 0;

    bpred_update_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst),
        .lk_req(lk_req), .lk_pc(lk_pc), .lk_gnt(lk_gnt),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .rs_valid(rs_valid), .rs_taken(rs_taken),
        .tp_en(tp_en), .tp_we(tp_we), .tp_br(tp_br), .tp_pc(tp_pc), .tp_hit(tp_hit),
        .flush(flush), .occ(occ), .err_underflow(err_underflow),
        .st_lookups(st_lookups), .st_mispred(st_mispred)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge, checks run 2ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; lk_req = 1'b1; lk_pc = 32'd77; rs_valid = 1'b0; rs_taken = 1'b0; tp_hit = 1'b1;
        tick(); tick();
        #1;
        checks++; if (lk_gnt !== 1'b0) begin $display("FAIL reset_lk_gnt got=%0b exp=0", lk_gnt); fails++; end
        checks++; if (tp_en !== 1'b0) begin $display("FAIL reset_tp_en got=%0b exp=0", tp_en); fails++; end
        checks++; if (tp_pc !== 32'd0) begin $display("FAIL reset_tp_pc got=%0d exp=0", tp_pc); fails++; end
        checks++; if (occ !== 3'd0) begin $display("FAIL reset_occ got=%0d exp=0", occ); fails++; end
        checks++; if ({pred_valid, pred_taken, flush, err_underflow} !== 4'b0000) begin
            $display("FAIL reset_flags got=%b exp=0000", {pred_valid, pred_taken, flush, err_underflow}); fails++; end
        checks++; if ({st_lookups, st_mispred} !== 32'd0) begin
            $display("FAIL reset_stats got=%0d/%0d exp=0/0", st_lookups, st_mispred); fails++; end
        $display("reset: occ=%0d lk_gnt=%0b", occ, lk_gnt);
        lk_req = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_lookup_update();
        lk_req = 1'b1; lk_pc = 32'd1024; tp_hit = 1'b1;
        #1;
        checks++; if ({lk_gnt, tp_en, tp_we} !== 3'b110) begin
            $display("FAIL lookup_port got=%b exp=110", {lk_gnt, tp_en, tp_we}); fails++; end
        checks++; if (tp_pc !== 32'd1024) begin $display("FAIL lookup_tp_pc got=%0d exp=1024", tp_pc); fails++; end
        tick();
        lk_req = 1'b0; tp_hit = 1'b0;
        #1;
        checks++; if ({pred_valid, pred_taken} !== 2'b11) begin
            $display("FAIL lookup_pred got=%b exp=11", {pred_valid, pred_taken}); fails++; end
        checks++; if (occ !== 3'd1) begin $display("FAIL lookup_occ got=%0d exp=1", occ); fails++; end
        rs_valid = 1'b1; rs_taken = 1'b1;
        #1;
        checks++; if ({tp_en, tp_we, tp_br, lk_gnt} !== 4'b1110) begin
            $display("FAIL update_port got=%b exp=1110", {tp_en, tp_we, tp_br, lk_gnt}); fails++; end
        checks++; if (tp_pc !== 32'd1024) begin $display("FAIL update_tp_pc got=%0d exp=1024", tp_pc); fails++; end
        tick();
        rs_valid = 1'b0;
        #1;
        checks++; if ({flush, pred_valid, pred_taken} !== 3'b001) begin
            $display("FAIL update_after got=%b exp=001", {flush, pred_valid, pred_taken}); fails++; end
        checks++; if (occ !== 3'd0) begin $display("FAIL update_occ got=%0d exp=0", occ); fails++; end
        $display("lookup_update: pc=1024 predicted taken, resolved taken, occ=%0d", occ);
    endtask

    task automatic test_mispredict();
        logic [2:0] hits;
        hits = 3'b101;
        for (int i = 0; i < 3; i++) begin
            lk_req = 1'b1; lk_pc = 32'd1025 + 32'(i); tp_hit = hits[i];
            tick();
        end
        lk_req = 1'b0;
        #1;
        checks++; if (occ !== 3'd3) begin $display("FAIL misp_occ_pre got=%0d exp=3", occ); fails++; end
        rs_valid = 1'b1; rs_taken = 1'b0;
        #1;
        checks++; if (tp_pc !== 32'd1025) begin $display("FAIL misp_tp_pc got=%0d exp=1025", tp_pc); fails++; end
        tick();
        rs_valid = 1'b0; lk_req = 1'b1; lk_pc = 32'd1100; tp_hit = 1'b0;
        #1;
        checks++; if ({flush, lk_gnt, tp_en} !== 3'b100) begin
            $display("FAIL misp_flush_cycle got=%b exp=100", {flush, lk_gnt, tp_en}); fails++; end
        checks++; if (occ !== 3'd0) begin $display("FAIL misp_occ got=%0d exp=0", occ); fails++; end
        tick();
        #1;
        checks++; if ({flush, lk_gnt} !== 2'b01) begin
            $display("FAIL misp_recover got=%b exp=01", {flush, lk_gnt}); fails++; end
        tick();
        lk_req = 1'b0; rs_valid = 1'b1; rs_taken = 1'b0;
        #1;
        checks++; if (tp_pc !== 32'd1100) begin $display("FAIL misp_new_head got=%0d exp=1100", tp_pc); fails++; end
        tick();
        rs_valid = 1'b0;
        #1;
        checks++; if ({flush, occ} !== 4'b0000) begin
            $display("FAIL misp_drain got=%b exp=0000", {flush, occ}); fails++; end
        $display("mispredict: head 1025 mispredicted, flushed 2 younger entries");
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            lk_req = 1'b1; lk_pc = 32'd2000 + 32'(i); tp_hit = 1'b1;
            #1;
            checks++; if (lk_gnt !== (i < 4)) begin
                $display("FAIL full_gnt%0d got=%0b exp=%0b", i, lk_gnt, (i < 4)); fails++; end
            tick();
        end
        #1;
        checks++; if (occ !== 3'd4) begin $display("FAIL full_occ got=%0d exp=4", occ); fails++; end
        rs_valid = 1'b1; rs_taken = 1'b1;
        #1;
        checks++; if ({lk_gnt, tp_we} !== 2'b01) begin
            $display("FAIL full_pop_prio got=%b exp=01", {lk_gnt, tp_we}); fails++; end
        tick();
        rs_valid = 1'b0;
        #1;
        checks++; if ({lk_gnt, occ} !== 4'b1011) begin
            $display("FAIL full_regrant got=%b exp=1011", {lk_gnt, occ}); fails++; end
        tick();
        lk_req = 1'b0;
        for (int i = 1; i < 5; i++) begin
            rs_valid = 1'b1; rs_taken = 1'b1;
            #1;
            checks++; if (tp_pc !== 32'd2000 + 32'(i)) begin
                $display("FAIL full_drain%0d got=%0d exp=%0d", i, tp_pc, 2000 + i); fails++; end
            tick();
        end
        rs_valid = 1'b0;
        #1;
        checks++; if ({flush, occ} !== 4'b0000) begin
            $display("FAIL full_end got=%b exp=0000", {flush, occ}); fails++; end
        $display("full: 4 grants, 5th stalled, drained with pointer wrap");
    endtask

    task automatic test_back_to_back();
        lk_req = 1'b1; lk_pc = 32'd3000; tp_hit = 1'b0;
        tick();
        lk_pc = 32'd3001; rs_valid = 1'b1; rs_taken = 1'b0;
        #1;
        checks++; if ({tp_we, lk_gnt} !== 2'b10) begin
            $display("FAIL b2b_same got=%b exp=10", {tp_we, lk_gnt}); fails++; end
        checks++; if (tp_pc !== 32'd3000) begin $display("FAIL b2b_tp_pc got=%0d exp=3000", tp_pc); fails++; end
        tick();
        rs_valid = 1'b0;
        #1;
        checks++; if ({lk_gnt, tp_we, flush} !== 3'b100) begin
            $display("FAIL b2b_later got=%b exp=100", {lk_gnt, tp_we, flush}); fails++; end
        checks++; if (tp_pc !== 32'd3001) begin $display("FAIL b2b_later_pc got=%0d exp=3001", tp_pc); fails++; end
        tick();
        lk_req = 1'b0;
        #1;
        checks++; if ({pred_valid, pred_taken, occ} !== 5'b10001) begin
            $display("FAIL b2b_pred got=%b exp=10001", {pred_valid, pred_taken, occ}); fails++; end
        rs_valid = 1'b1; rs_taken = 1'b0;
        tick();
        rs_valid = 1'b0;
        #1;
        checks++; if ({pred_valid, pred_taken, occ} !== 5'b00000) begin
            $display("FAIL b2b_hold got=%b exp=00000", {pred_valid, pred_taken, occ}); fails++; end
        $display("back_to_back: update served first, lookup granted next cycle");
    endtask

    task automatic test_underflow();
        rs_valid = 1'b1; rs_taken = 1'b1;
        #1;
        checks++; if ({tp_en, tp_we} !== 2'b00) begin
            $display("FAIL uf_port got=%b exp=00", {tp_en, tp_we}); fails++; end
        tick();
        rs_valid = 1'b0;
        tick();
        checks++; if ({err_underflow, occ} !== 4'b1000) begin
            $display("FAIL uf_sticky got=%b exp=1000", {err_underflow, occ}); fails++; end
        for (int i = 0; i < 3; i++) begin
            lk_req = 1'b1; lk_pc = 32'd5000 + 32'(i); tp_hit = 1'b0;
            tick();
        end
        checks++; if (occ !== 3'd3) begin $display("FAIL uf_occ3 got=%0d exp=3", occ); fails++; end
        rst = 1'b1;
        #1;
        checks++; if ({lk_gnt, tp_en} !== 2'b00) begin
            $display("FAIL rst_comb got=%b exp=00", {lk_gnt, tp_en}); fails++; end
        tick();
        lk_req = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if ({err_underflow, pred_valid, occ} !== 5'b00000) begin
            $display("FAIL rst_mid got=%b exp=00000", {err_underflow, pred_valid, occ}); fails++; end
        $display("underflow: sticky error, cleared by mid-stream reset");
    endtask

    task automatic test_stats();
        logic [15:0] exp_lk;
        logic [15:0] exp_mp;
`ifdef BPRED_STATS_EN
        exp_lk = 16'd3; exp_mp = 16'd1;
`else
        exp_lk = 16'd0; exp_mp = 16'd0;
`endif
        for (int i = 0; i < 3; i++) begin
            lk_req = 1'b1; lk_pc = 32'd4000 + 32'(i); tp_hit = 1'b1;
            tick();
        end
        lk_req = 1'b0; rs_valid = 1'b1; rs_taken = 1'b0;
        tick();
        rs_valid = 1'b0;
        #1;
        checks++; if (flush !== 1'b1) begin $display("FAIL stats_flush got=%0b exp=1", flush); fails++; end
        tick();
        checks++; if (st_lookups !== exp_lk) begin
            $display("FAIL stats_lookups got=%0d exp=%0d", st_lookups, exp_lk); fails++; end
        checks++; if (st_mispred !== exp_mp) begin
            $display("FAIL stats_mispred got=%0d exp=%0d", st_mispred, exp_mp); fails++; end
        $display("stats: lookups=%0d mispred=%0d", st_lookups, st_mispred);
    endtask

    initial begin
        rst = 1'b1; lk_req = 1'b0; lk_pc = '0; rs_valid = 1'b0; rs_taken = 1'b0; tp_hit = 1'b0;
        test_reset();
        test_lookup_update();
        test_mispredict();
        test_full();
        test_back_to_back();
        test_underflow();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bpred_update_ctrl.md
BPRED_UPDATE_CTRL -- requirements
Module: bpred_update_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, in-flight branch FIFO entries (power of 2, >=2).
REQ-002 Parameter: PC_W, 32, program-counter width.
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: lk_req  in  1  fetch requests prediction lookup; held until granted.
REQ-006 Port: lk_pc  in  PC_W  PC of branch being looked up.
REQ-007 Port: lk_gnt  out  1  lookup accepted this cycle (combinational).
REQ-008 Port: pred_valid  out  1  registered prediction strobe, one cycle after lk_gnt.
REQ-009 Port: pred_taken  out  1  registered predicted direction, valid with pred_valid.
REQ-010 Port: rs_valid  in  1  execute resolves oldest in-flight branch (in-order).
REQ-011 Port: rs_taken  in  1  actual outcome of resolved branch.
REQ-012 Port: tp_en / tp_we / tp_br  out  1 each  predictor port enable, write-enable, outcome to train.
REQ-013 Port: tp_pc  out  PC_W  predictor port PC.
REQ-014 Port: tp_hit  in  1  predictor taken/not-taken for tp_pc, combinational same cycle.
REQ-015 Port: flush  out  1  registered one-cycle mispredict pulse.
REQ-016 Port: occ  out  clog2(DEPTH)+1  FIFO occupancy; full/empty derived from occ.
REQ-017 Port: err_underflow  out  1  sticky, rs_valid seen with empty FIFO.
REQ-018 Port: st_lookups / st_mispred  out  16 each  statistics counters (see Configuration).

Function
REQ-019 The block SHALL arbitrate the single predictor port per cycle: update priority over lookup.
REQ-020 Update cycle (rs_valid=1, occ>0): tp_en=1, tp_we=1, tp_pc=head PC, tp_br=rs_taken, lk_gnt=0; head popped at the edge.
REQ-021 Lookup cycle (no update, lk_req=1, occ<DEPTH, state RUN): tp_en=1, tp_we=0, tp_pc=lk_pc, lk_gnt=1; {lk_pc, tp_hit} pushed at the edge.
REQ-022 Idle cycle: tp_en=0, tp_we=0, tp_pc=0, tp_br=0.
REQ-023 pred_valid SHALL be 1 exactly the cycle after each lk_gnt, with pred_taken = captured tp_hit; else pred_valid=0, pred_taken holds.
REQ-024 Mispredict: update where rs_taken != stored prediction of head SHALL set flush=1 next cycle and clear FIFO (occ=0) at the same edge.
REQ-025 FSM states RUN, FLUSH: RUN->FLUSH on mispredict; FLUSH->RUN after exactly one cycle; lk_gnt=0 in FLUSH; rs_valid in FLUSH treated as underflow.
REQ-026 Full (occ=DEPTH): lk_gnt=0; requester stalls; no overwrite.
REQ-027 Underflow: rs_valid with occ=0 SHALL cause no port access, no pop, err_underflow=1 until reset.
REQ-028 Same-cycle rs_valid and lk_req: update only; lookup granted on a later free cycle.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; occ never exceeds DEPTH.

Reset
REQ-030 rst=1 at an edge SHALL set state RUN, occ=0, pointers 0, pred_valid=0, pred_taken=0, flush=0, err_underflow=0, stats 0.
REQ-031 Reset mid-operation SHALL discard all in-flight entries and pending flush; lk_gnt and tp_* combinational outputs SHALL be 0 while rst=1.

Configuration
REQ-032 Macro BPRED_STATS_EN defined: st_lookups increments per lk_gnt, st_mispred per mispredict, both saturate at 16'hFFFF.
REQ-033 Macro BPRED_STATS_EN undefined: counters not built, st_lookups and st_mispred tied 0; all other behaviour identical.

Verification
REQ-034 Lookup pc=1024, tp_hit=1, then rs_valid rs_taken=1 -> lk_gnt=1, next cycle pred_valid=1 pred_taken=1; update tp_we=1 tp_pc=1024 tp_br=1, flush=0, occ 1->0.
REQ-035 Lookup pc=1025 tp_hit=1, resolve rs_taken=0 with 2 younger entries queued -> flush=1 one cycle later, occ=0, lk_gnt=0 for one FLUSH cycle.
REQ-036 Five back-to-back lookups, DEPTH=4 -> 4 grants, fifth lk_gnt=0 until a resolve pops, occ=4 max.
REQ-037 rs_valid and lk_req same cycle with occ=1 -> tp_we=1, lk_gnt=0; lookup granted next cycle.
REQ-038 rs_valid with occ=0 -> tp_en=0, err_underflow=1 sticky; rst=1 mid-stream with occ=3 -> occ=0, err_underflow=0 after edge.
REQ-039 With BPRED_STATS_EN, 3 grants and 1 mispredict -> st_lookups=3, st_mispred=1; without macro both 0.
